// File: rtl/regfile_write_demux_if.sv
// rtl/regfile_write_demux_if.sv - request/write-port bundle for the windowed register-file write demux
interface regfile_write_demux_if #(
  parameter int NWIN = 4,
  parameter int DW   = 32
);
  localparam int NPHYS = 8 + 16 * NWIN;
  localparam int IW    = $clog2(NPHYS);
  localparam int CW    = $clog2(NWIN);

  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_rd;
  logic [CW-1:0]    req_cwp;
  logic [DW-1:0]    req_data;
  logic [NPHYS-1:0] wr_en;
  logic [IW-1:0]    wr_idx;
  logic [DW-1:0]    wr_data;
  logic             wr_ready;
  logic             r0_drop;
  logic             fwd_valid;

  // Requester / register-array side
  modport master (
    output req_valid, req_rd, req_cwp, req_data, wr_ready,
    input  req_ready, wr_en, wr_idx, wr_data, r0_drop, fwd_valid
  );

  // Demux side
  modport slave (
    input  req_valid, req_rd, req_cwp, req_data, wr_ready,
    output req_ready, wr_en, wr_idx, wr_data, r0_drop, fwd_valid
  );
endinterface

// File: rtl/regfile_write_demux.sv
// rtl/regfile_write_demux.sv - maps a logical (rd, cwp) write onto one physical register with a one-hot enable
module regfile_write_demux #(
  parameter int NWIN = 4,
  parameter int DW   = 32
) (
  input logic                   i_clk,
  input logic                   i_reset,
  regfile_write_demux_if.slave  io_bus
);
  localparam int NPHYS = 8 + 16 * NWIN;
  localparam int IW    = $clog2(NPHYS);
  localparam int WW    = $clog2(16 * NWIN);

  logic             r_out_valid;
  logic [NPHYS-1:0] r_wr_en;
  logic [IW-1:0]    r_wr_idx;
  logic [DW-1:0]    r_wr_data;
  logic             r_r0_drop;

  logic             w_req_ready;
  logic             w_accept;
  logic             w_retire;
  logic             w_is_r0;
  logic [4:0]       w_rd_off;
  logic [WW-1:0]    w_win_off;
  logic [IW-1:0]    w_phys;

  assign w_req_ready = !r_out_valid || io_bus.wr_ready;
  assign w_accept    = io_bus.req_valid && w_req_ready;
  assign w_retire    = r_out_valid && io_bus.wr_ready;
  assign w_is_r0     = (io_bus.req_rd == 5'd0);

  // Logical-to-physical index: globals pass through, windowed registers wrap within the 16*NWIN ring
  always_comb begin
    w_rd_off  = io_bus.req_rd - 5'd8;
    w_win_off = WW'({io_bus.req_cwp, 4'b0000}) + WW'(w_rd_off);
    if (io_bus.req_rd < 5'd8) begin
      w_phys = IW'(io_bus.req_rd);
    end else begin
      w_phys = IW'(8) + IW'(w_win_off);
    end
  end

  // Single output stage: load on accept (r0 excepted), clear on retire, replace on both
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid <= 1'b0;
      r_wr_en     <= '0;
      r_wr_idx    <= '0;
      r_wr_data   <= '0;
      r_r0_drop   <= 1'b0;
    end else begin
      r_r0_drop <= w_accept && w_is_r0;
      if (w_accept && !w_is_r0) begin
        r_out_valid <= 1'b1;
        r_wr_idx    <= w_phys;
        r_wr_data   <= io_bus.req_data;
        r_wr_en     <= NPHYS'(1) << w_phys;
      end else if (w_retire) begin
        r_out_valid <= 1'b0;
        r_wr_en     <= '0;
      end
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.wr_en     = r_wr_en;
  assign io_bus.wr_idx    = r_wr_idx;
  assign io_bus.wr_data   = r_wr_data;
  assign io_bus.r0_drop   = r_r0_drop;
  assign io_bus.fwd_valid = r_out_valid;
endmodule

// File: tb/tb_regfile_write_demux.sv
// tb/tb_regfile_write_demux.sv - randomized self-checking bench for regfile_write_demux
module tb_regfile_write_demux;
  localparam int NW    = 4;
  localparam int NPHYS = 8 + 16 * NW;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  regfile_write_demux_if #(.NWIN(NW), .DW(32)) bus ();

  regfile_write_demux #(.NWIN(NW), .DW(32)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .io_bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic int ref_phys(input int rd, input int cwp);
    if (rd < 8) return rd;
    return 8 + ((16 * cwp + (rd - 8)) % (16 * NW));
  endfunction

  function automatic logic [NPHYS-1:0] onehot(input int idx);
    logic [NPHYS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int rd, input int cwp, input logic [31:0] d, input bit rdy);
    bus.req_valid = v;
    bus.req_rd    = 5'(rd);
    bus.req_cwp   = 2'(cwp);
    bus.req_data  = d;
    bus.wr_ready  = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 9, 0, 32'hFFFF_FFFF, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL reset_wr_en got=%h exp=0", bus.wr_en); end
    checks++; if (bus.wr_idx !== '0) begin failures++; $display("FAIL reset_wr_idx got=%0d exp=0", bus.wr_idx); end
    checks++; if (bus.wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
    checks++; if (bus.r0_drop !== 1'b0) begin failures++; $display("FAIL reset_r0_drop got=%b exp=0", bus.r0_drop); end
    checks++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%b exp=0", bus.fwd_valid); end
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 5, 2, 32'hDEAD_BEEF, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL basic_ready got=%b exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.wr_en !== onehot(5)) begin failures++; $display("FAIL basic_wr_en got=%h exp=%h", bus.wr_en, onehot(5)); end
    checks++; if (bus.wr_idx !== 7'd5) begin failures++; $display("FAIL basic_wr_idx got=%0d exp=5", bus.wr_idx); end
    checks++; if (bus.wr_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL basic_wr_data got=%h exp=deadbeef", bus.wr_data); end
    checks++; if (bus.fwd_valid !== 1'b1) begin failures++; $display("FAIL basic_fwd got=%b exp=1", bus.fwd_valid); end
    tick();
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL basic_idle_wr_en got=%h exp=0", bus.wr_en); end
    checks++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL basic_idle_fwd got=%b exp=0", bus.fwd_valid); end
    checks++; if (bus.wr_idx !== 7'd5) begin failures++; $display("FAIL basic_hold_idx got=%0d exp=5", bus.wr_idx); end
  endtask

  task automatic test_mapping();
    int rd_t[6]  = '{8, 16, 31, 24, 8, 24};
    int cwp_t[6] = '{0, 1, 3, 3, 1, 0};
    int exp_t[6] = '{8, 32, 15, 8, 24, 24};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, rd_t[i], cwp_t[i], 32'h1000 + 32'(i), 1'b1);
      tick();
      bus.req_valid = 1'b0;
      checks++; if (bus.wr_idx !== 7'(exp_t[i])) begin failures++; $display("FAIL map_idx case=%0d got=%0d exp=%0d", i, bus.wr_idx, exp_t[i]); end
      checks++; if (bus.wr_en !== onehot(exp_t[i])) begin failures++; $display("FAIL map_wr_en case=%0d got=%h exp=%h", i, bus.wr_en, onehot(exp_t[i])); end
      tick();
    end
  endtask

  task automatic test_r0();
    drive(1'b1, 0, 1, 32'h1234, 1'b1);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL r0_ready got=%b exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.r0_drop !== 1'b1) begin failures++; $display("FAIL r0_drop_pulse got=%b exp=1", bus.r0_drop); end
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL r0_wr_en got=%h exp=0", bus.wr_en); end
    checks++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL r0_fwd got=%b exp=0", bus.fwd_valid); end
    tick();
    checks++; if (bus.r0_drop !== 1'b0) begin failures++; $display("FAIL r0_drop_end got=%b exp=0", bus.r0_drop); end
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL r0_wr_en_after got=%h exp=0", bus.wr_en); end
  endtask

  task automatic test_backpressure();
    int ia, ib;
    ia = ref_phys(9, 1);
    ib = ref_phys(20, 2);
    drive(1'b1, 9, 1, 32'hAAAA_0001, 1'b1);
    tick();
    drive(1'b1, 20, 2, 32'hBBBB_0002, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, bus.req_ready); end
      checks++; if (bus.wr_en !== onehot(ia) || bus.wr_idx !== 7'(ia) || bus.wr_data !== 32'hAAAA_0001)
        begin failures++; $display("FAIL bp_hold cyc=%0d got idx=%0d data=%h exp idx=%0d data=aaaa0001", i, bus.wr_idx, bus.wr_data, ia); end
      tick();
    end
    bus.wr_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL bp_release_ready got=%b exp=1", bus.req_ready); end
    tick();
    bus.req_valid = 1'b0;
    checks++; if (bus.wr_en !== onehot(ib) || bus.wr_idx !== 7'(ib) || bus.wr_data !== 32'hBBBB_0002)
      begin failures++; $display("FAIL bp_b_loaded got idx=%0d data=%h exp idx=%0d data=bbbb0002", bus.wr_idx, bus.wr_data, ib); end
    tick();
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL bp_drain got=%h exp=0", bus.wr_en); end
  endtask

  task automatic test_streaming();
    int rd, cwp, e;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) begin
      rd  = $urandom_range(31, 1);
      cwp = $urandom_range(NW - 1, 0);
      d   = $urandom;
      e   = ref_phys(rd, cwp);
      drive(1'b1, rd, cwp, d, 1'b1);
      tick();
      checks++; if (bus.wr_en !== onehot(e) || bus.wr_data !== d)
        begin failures++; $display("FAIL stream_%0d got en=%h data=%h exp en=%h data=%h", i, bus.wr_en, bus.wr_data, onehot(e), d); end
      checks++; if ($countones(bus.wr_en) > 1) begin failures++; $display("FAIL stream_popcount_%0d got=%0d exp<=1", i, $countones(bus.wr_en)); end
    end
    bus.req_valid = 1'b0;
    tick();
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL stream_idle got=%h exp=0", bus.wr_en); end
  endtask

  task automatic test_random();
    bit          mv = 1'b0, mdrop, v, rdy, acc;
    int          midx = 0, rd, cwp;
    logic [31:0] mdata = '0, d;
    logic [NPHYS-1:0] exp_en;
    for (int i = 0; i < 300; i++) begin
      v   = ($urandom_range(3, 0) != 0);
      rd  = ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(31, 0);
      cwp = $urandom_range(NW - 1, 0);
      d   = $urandom;
      rdy = ($urandom_range(2, 0) != 0);
      drive(v, rd, cwp, d, rdy);
      #1;
      checks++; if (bus.req_ready !== (!mv || rdy)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", i, bus.req_ready, !mv || rdy); end
      acc   = v && (!mv || rdy);
      mdrop = acc && (rd == 0);
      if (acc && rd != 0) begin
        mv = 1'b1; midx = ref_phys(rd, cwp); mdata = d;
      end else if (mv && rdy) begin
        mv = 1'b0;
      end
      tick();
      exp_en = mv ? onehot(midx) : '0;
      checks++; if (bus.wr_en !== exp_en) begin failures++; $display("FAIL rnd_wr_en cyc=%0d got=%h exp=%h", i, bus.wr_en, exp_en); end
      checks++; if (bus.fwd_valid !== mv) begin failures++; $display("FAIL rnd_fwd cyc=%0d got=%b exp=%b", i, bus.fwd_valid, mv); end
      checks++; if (bus.r0_drop !== mdrop) begin failures++; $display("FAIL rnd_r0_drop cyc=%0d got=%b exp=%b", i, bus.r0_drop, mdrop); end
      checks++; if (bus.wr_idx !== 7'(midx) || bus.wr_data !== mdata)
        begin failures++; $display("FAIL rnd_payload cyc=%0d got idx=%0d data=%h exp idx=%0d data=%h", i, bus.wr_idx, bus.wr_data, midx, mdata); end
      checks++; if ($countones(bus.wr_en) > 1) begin failures++; $display("FAIL rnd_popcount cyc=%0d got=%0d exp<=1", i, $countones(bus.wr_en)); end
    end
    drive(1'b0, 0, 0, '0, 1'b1);
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 12, 1, 32'hCAFE_0012, 1'b0);
    tick();
    checks++; if (bus.fwd_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%b exp=1", bus.fwd_valid); end
    reset = 1'b1;
    drive(1'b1, 13, 2, 32'hCAFE_0013, 1'b1);
    tick();
    reset = 1'b0;
    bus.req_valid = 1'b0;
    checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL rstmid_wr_en got=%h exp=0", bus.wr_en); end
    checks++; if (bus.fwd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_fwd got=%b exp=0", bus.fwd_valid); end
    checks++; if (bus.wr_idx !== '0 || bus.wr_data !== '0) begin failures++; $display("FAIL rstmid_payload got idx=%0d data=%h exp 0", bus.wr_idx, bus.wr_data); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.wr_en !== '0) begin failures++; $display("FAIL rstmid_never_emitted cyc=%0d got=%h exp=0", i, bus.wr_en); end
    end
  endtask

  initial begin
    drive(1'b0, 0, 0, '0, 1'b0);
    reset = 1'b1;
    test_reset();
    test_basic();
    test_mapping();
    test_r0();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
